// File: rtl/hilo_unit_if.sv
// Request/result bundle between the register-file stage and the HI/LO multiply/divide unit.
interface hilo_unit_if;
  localparam int unsigned W = 32;

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] move_data;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, mthi, mtlo, move_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, mthi, mtlo, move_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_unit.sv
// Iterative 32-step multiply/divide with HI/LO result registers and MTHI/MTLO writes.
// Shares one 64-bit accumulator between shift-add multiply and restoring divide.
module hilo_unit (
  input logic        clock,
  input logic        clear_n,
  hilo_unit_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 2 * W;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           neg_res;
  logic           neg_rem;
  logic           div0;
  logic [W-1:0]   raw_a;
  logic [W-1:0]   divm;
  logic [AW-1:0]  acc;
  logic [W-1:0]   hi_q, lo_q;
  logic           busy_q, done_q;

  // Operand conditioning at the start edge
  logic           a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;

  assign a_neg = bus.op[0] & bus.operand_a[W-1];
  assign b_neg = bus.op[0] & bus.operand_b[W-1];
  assign mag_a = a_neg ? (~bus.operand_a + W'(1)) : bus.operand_a;
  assign mag_b = b_neg ? (~bus.operand_b + W'(1)) : bus.operand_b;

  // One iteration step for each algorithm
  logic [W:0]     mul_sum;
  logic [AW-1:0]  mul_next;
  logic [W:0]     div_shift;
  logic           div_ok;
  logic [W-1:0]   div_rem;
  logic [AW-1:0]  div_next;

  assign mul_sum   = {1'b0, acc[AW-1:W]} + (acc[0] ? {1'b0, divm} : (W+1)'(0));
  assign mul_next  = {mul_sum, acc[W-1:1]};
  assign div_shift = {acc[AW-1:W], acc[W-1]};
  assign div_ok    = (div_shift >= {1'b0, divm});
  assign div_rem   = div_shift[W-1:0] - divm;
  assign div_next  = {(div_ok ? div_rem : div_shift[W-1:0]), acc[W-2:0], div_ok};

  // Sign correction and special cases applied on the FINISH edge
  logic [AW-1:0]  prod;
  logic [W-1:0]   quo, rem;
  logic [W-1:0]   res_hi, res_lo;

  assign prod = neg_res ? (~acc + AW'(1)) : acc;
  assign quo  = neg_res ? (~acc[W-1:0] + W'(1)) : acc[W-1:0];
  assign rem  = neg_rem ? (~acc[AW-1:W] + W'(1)) : acc[AW-1:W];

  always_comb begin
    res_hi = prod[AW-1:W];
    res_lo = prod[W-1:0];
    if (is_div) begin
      if (div0) begin
        res_hi = raw_a;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CW'(W - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      raw_a   <= '0;
      divm    <= '0;
      acc     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state == FINISH);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt     <= '0;
            is_div  <= bus.op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= bus.op[1] & (bus.operand_b == '0);
            raw_a   <= bus.operand_a;
            divm    <= bus.op[1] ? mag_b : mag_a;
            acc     <= {{W{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
          end else begin
            if (bus.mthi) hi_q <= bus.move_data;
            if (bus.mtlo) lo_q <= bus.move_data;
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CW'(1);
        end
        FINISH: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: expected HI/LO queued at start, checked on done.
module tb_hilo_unit;
  logic clock;
  logic clear_n;

  hilo_unit_if bus ();

  hilo_unit dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference result computed with native wide arithmetic
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(a) * 64'(b); r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = 64'(sa * sb);    r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin r.hi = a; r.lo = '1; end
        else begin r.hi = a % b; r.lo = a / b; end
      end
      default: begin
        if (b == 0) begin r.hi = a; r.lo = '1; end
        else begin sq = sa / sb; sr = sa % sb; r.hi = 32'(sr); r.lo = 32'(sq); end
      end
    endcase
    return r;
  endfunction

  // Called just after a negedge; returns just after a negedge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input string tag,
                       input int disturb, input logic with_mtlo);
    logic [31:0] old_hi, old_lo;
    int          n_busy;
    bit          seen;
    exp_t        e;
    exp_q.push_back('{hi: ehi, lo: elo});
    old_hi = bus.hi;
    old_lo = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    bus.mtlo = with_mtlo; bus.move_data = 32'hA5A5_0000;
    @(negedge clock);
    bus.start = 1'b0; bus.mtlo = 1'b0;
    if (with_mtlo) check({tag, "_mtlo_drop"}, 64'(bus.lo), 64'(old_lo));
    n_busy = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.busy) n_busy++;
      if (n_busy == 16 && i == 15) check({tag, "_hold_hi"}, 64'(bus.hi), 64'(old_hi));
      if (i == 9 && disturb == 1) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'd5; bus.operand_b = 32'd5;
      end
      if (i == 9 && disturb == 2) begin
        bus.mthi = 1'b1; bus.move_data = 32'hDEADBEEF;
      end
      @(negedge clock);
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(n_busy), 64'd33);
    check({tag, "_busy_clr"}, 64'(bus.busy), 64'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
    end
    @(negedge clock);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic do_model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input string tag);
    exp_t r;
    r = model(op, a, b);
    do_op(op, a, b, r.hi, r.lo, tag, 0, 1'b0);
  endtask

  initial begin
    bit done_seen;
    clear_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.move_data = '0;
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);

    // Put nonzero state in HI/LO, then reset asynchronously mid-cycle
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.move_data = 32'h1234_5678;
    @(negedge clock);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("both_move_hi", 64'(bus.hi), 64'h1234_5678);
    check("both_move_lo", 64'(bus.lo), 64'h1234_5678);
    #2 clear_n = 1'b0;
    #1;
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    @(negedge clock);
    clear_n = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_hi", 64'(bus.hi), 64'd0);
    check("idle_lo", 64'(bus.lo), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);

    do_op(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, "multu_7x6", 0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5", 0, 1'b0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2", 0, 1'b0);
    do_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7", 0, 1'b0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf", 0, 1'b0);
    do_op(2'b10, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, "divu_by0", 0, 1'b0);
    do_op(2'b11, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, "div_by0", 0, 1'b0);

    // Protocol: restart and MTHI while busy are ignored
    do_op(2'b00, 32'd11, 32'd13, 32'd0, 32'd143, "restart_ign", 1, 1'b0);
    do_op(2'b10, 32'd50, 32'd8, 32'd2, 32'd6, "mthi_busy_ign", 2, 1'b0);

    bus.mthi = 1'b1; bus.move_data = 32'hDEADBEEF;
    @(negedge clock);
    bus.mthi = 1'b0;
    check("mthi_idle_hi", 64'(bus.hi), 64'hDEAD_BEEF);
    check("mthi_idle_lo", 64'(bus.lo), 64'd6);
    check("mthi_idle_done", 64'(bus.done), 64'd0);

    do_op(2'b00, 32'd9, 32'd9, 32'd0, 32'd81, "start_mtlo", 0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'(k % 4);
      a  = $urandom;
      b  = (k == 6) ? 32'hFFFF_FFFF : $urandom;
      do_model_op(op, a, b, $sformatf("rand%0d", k));
    end

    // Reset in the middle of RUN aborts with no result and no done
    bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd1000; bus.operand_b = 32'd1000;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (20) @(negedge clock);
    check("mid_busy", 64'(bus.busy), 64'd1);
    #2 clear_n = 1'b0;
    #1;
    check("mid_rst_hi", 64'(bus.hi), 64'd0);
    check("mid_rst_lo", 64'(bus.lo), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clock);
    clear_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) done_seen = 1'b1;
    end
    check("mid_no_done", 64'(done_seen), 64'd0);
    check("mid_no_busy", 64'(bus.busy), 64'd0);
    check("mid_lo_zero", 64'(bus.lo), 64'd0);

    do_op(2'b00, 32'd3, 32'd3, 32'd0, 32'd9, "multu_3x3", 0, 1'b0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
